// File: rtl/minirv_pkg.sv
// rtl/minirv_pkg.sv - shared types and constants for the miniRV data-memory responder
package minirv_pkg;

  localparam int XLEN       = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

  typedef enum logic [1:0] {OP_LW, OP_LBU, OP_SW, OP_SB} mem_op_t;

  function automatic mem_op_t decode_op(input logic is_write, input logic is_byte);
    case ({is_write, is_byte})
      2'b00:   return OP_LW;
      2'b01:   return OP_LBU;
      2'b10:   return OP_SW;
      default: return OP_SB;
    endcase
  endfunction

endpackage

// File: rtl/minirv_lane_sel.sv
// rtl/minirv_lane_sel.sv - byte-lane merge for SB and zero-extended byte extract for LBU
module minirv_lane_sel
  import minirv_pkg::*;
(
  input  logic [$clog2(BYTE_LANES)-1:0] i_lane,
  input  logic [XLEN-1:0]               i_old_word,
  input  logic [7:0]                    i_wbyte,
  output logic [XLEN-1:0]               o_merged,
  output logic [XLEN-1:0]               o_rbyte_zx
);

  logic [4:0]      w_shift;
  logic [XLEN-1:0] w_lane_mask;
  logic [XLEN-1:0] w_shifted_old;

  assign w_shift       = {i_lane, 3'b000};
  assign w_lane_mask   = XLEN'(8'hFF) << w_shift;
  assign w_shifted_old = i_old_word >> w_shift;

  assign o_merged   = (i_old_word & ~w_lane_mask) | (XLEN'(i_wbyte) << w_shift);
  assign o_rbyte_zx = XLEN'(w_shifted_old[7:0]);

endmodule

// File: rtl/minirv_dmem_responder.sv
// rtl/minirv_dmem_responder.sv - single-outstanding LW/LBU/SW/SB responder over a word array
module minirv_dmem_responder
  import minirv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic            req_byte,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);

  localparam int              AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int              CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [XLEN-1:0] DEPTH_L = XLEN'(DEPTH_WORDS);

  state_t          r_state;
  logic            r_write;
  logic            r_byte;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [CW-1:0]   r_cnt;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_rdata;
  logic            r_rsp_err;
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  mem_op_t         w_op;
  logic            w_err;
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_merged;
  logic [XLEN-1:0] w_rbyte;

  assign w_op   = decode_op(r_write, r_byte);
  assign w_idx  = r_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_err  = (!r_byte && (r_addr[1:0] != 2'b00)) || ({2'b00, r_addr[XLEN-1:2]} >= DEPTH_L);

  minirv_lane_sel u_lane_sel (
    .i_lane     (r_addr[1:0]),
    .i_old_word (w_word),
    .i_wbyte    (r_wdata[7:0]),
    .o_merged   (w_merged),
    .o_rbyte_zx (w_rbyte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_byte      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_byte  <= req_byte;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (WAIT_CYCLES > 0) begin
              r_state <= WAIT;
              r_cnt   <= CW'(WAIT_CYCLES - 1);
            end else begin
              r_state <= EXEC;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) r_state <= EXEC;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        EXEC: begin
          r_rsp_err   <= w_err;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
          if (w_err)              r_rsp_rdata <= '0;
          else if (w_op == OP_LW)  r_rsp_rdata <= w_word;
          else if (w_op == OP_LBU) r_rsp_rdata <= w_rbyte;
          else                     r_rsp_rdata <= '0;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Array has no reset; stores only ever commit from EXEC, so a reset earlier drops them.
  always_ff @(posedge clk) begin
    if (r_state == EXEC && !w_err) begin
      if (w_op == OP_SW)      r_mem[w_idx] <= r_wdata;
      else if (w_op == OP_SB) r_mem[w_idx] <= w_merged;
    end
  end

  assign req_ready = (r_state == IDLE) && !rst;
  assign busy      = (r_state != IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_minirv_dmem_responder.sv
// tb/tb_minirv_dmem_responder.sv - bench for minirv_dmem_responder with WAIT_CYCLES 2 and 0
module tb_minirv_dmem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid, req_write, req_byte, rsp_ready;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rdy_a, rv_a, err_a, busy_a, rdy_b, rv_b, err_b, busy_b;
  logic [31:0] rd_a, rd_b;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [7:0]  bmem [2][1024];

  minirv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(rdy_a), .req_write(req_write[0]), .req_byte(req_byte[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready[0]), .rsp_rdata(rd_a), .rsp_err(err_a), .busy(busy_a)
  );

  minirv_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(rdy_b), .req_write(req_write[1]), .req_byte(req_byte[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready[1]), .rsp_rdata(rd_b), .rsp_err(err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic logic g_ready(input int s);  return (s != 0) ? rdy_b : rdy_a; endfunction
  function automatic logic g_valid(input int s);  return (s != 0) ? rv_b  : rv_a;  endfunction
  function automatic logic g_err(input int s);    return (s != 0) ? err_b : err_a; endfunction
  function automatic logic [31:0] g_rdata(input int s); return (s != 0) ? rd_b : rd_a; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Byte-addressed reference: a word is four consecutive bytes, little-endian.
  task automatic model(input int s, input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] erd, output logic ee);
    ee  = ((!b) && (a % 4 != 0)) || ((a / 4) >= DEPTH);
    erd = 32'h0;
    if (!ee) begin
      if (w && b)       bmem[s][a[9:0]] = d[7:0];
      else if (w)       for (int k = 0; k < 4; k++) bmem[s][a[9:0] + k] = d[8*k +: 8];
      else if (b)       erd = {24'h0, bmem[s][a[9:0]]};
      else              for (int k = 0; k < 4; k++) erd[8*k +: 8] = bmem[s][a[9:0] + k];
    end
  endtask

  task automatic xact(input int s, input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat);
    bit got;
    got = 0; lat = 0; rd = 32'h0; e = 1'b0;
    @(negedge clk);
    req_valid[s] = 1'b1; req_write[s] = w; req_byte[s] = b;
    req_addr[s] = a; req_wdata[s] = d; rsp_ready[s] = 1'b1;
    chk("req_ready_idle", {31'h0, g_ready(s)}, 32'h1);
    @(posedge clk);
    while (!got && lat < 50) begin
      @(negedge clk);
      lat++;
      req_valid[s] = 1'b0;
      if (g_valid(s)) begin
        got = 1; rd = g_rdata(s); e = g_err(s);
      end
    end
    chk("rsp_timeout", {31'h0, got}, 32'h1);
  endtask

  task automatic do_op(input int s, input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
    logic [31:0] erd, rd;
    logic        ee, e;
    int          lat;
    model(s, w, b, a, d, erd, ee);
    xact(s, w, b, a, d, rd, e, lat);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_err"}, {31'h0, e}, {31'h0, ee});
    chk({tag, "_lat"}, 32'(lat), (s != 0) ? 32'd2 : 32'd4);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 8)       return 32'($urandom_range(0, 63));
    else if (r == 8) return 32'h400 + 32'($urandom_range(0, 255));
    else             return $urandom | 32'h400;
  endfunction

  initial begin
    logic [31:0] hold_rd, erd;
    logic        hold_err, ee;
    int          n;

    req_valid = '0; req_write = '0; req_byte = '0; rsp_ready = '0;
    for (int s = 0; s < 2; s++) begin req_addr[s] = '0; req_wdata[s] = '0; end

    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'h0, rv_a}, 32'h0);
    chk("rst_rdata", rd_a, 32'h0);
    chk("rst_err", {31'h0, err_a}, 32'h0);
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_req_ready", {31'h0, rdy_a}, 32'h0);
    chk("rst_b_rsp_valid", {31'h0, rv_b}, 32'h0);
    rst = 1'b0;
    #1 chk("post_rst_req_ready", {31'h0, rdy_a}, 32'h1);

    do_op(0, 1, 0, 32'h10, 32'hDEADBEEF, "sw_10");
    do_op(0, 0, 0, 32'h10, 32'h0, "lw_10");
    do_op(0, 1, 1, 32'h11, 32'h00000055, "sb_11");
    do_op(0, 0, 0, 32'h10, 32'h0, "lw_10_merged");
    do_op(0, 0, 1, 32'h13, 32'h0, "lbu_13");
    do_op(0, 0, 1, 32'h11, 32'h0, "lbu_11");
    do_op(0, 0, 0, 32'h12, 32'h0, "lw_misaligned");
    do_op(0, 1, 0, 32'h12, 32'h12345678, "sw_misaligned");
    do_op(0, 0, 0, 32'h10, 32'h0, "lw_10_unchanged");
    do_op(0, 0, 1, 32'h12, 32'h0, "lbu_12");
    do_op(0, 0, 0, 32'h400, 32'h0, "lw_oob");
    do_op(0, 1, 0, 32'h3FC, 32'hCAFEF00D, "sw_top");
    do_op(0, 0, 0, 32'h3FC, 32'h0, "lw_top");

    // Response back-pressure with a competing request held on the bus.
    model(0, 0, 0, 32'h10, 32'h0, erd, ee);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_byte[0] = 1'b0; req_addr[0] = 32'h10; rsp_ready[0] = 1'b0;
    @(posedge clk);
    n = 0;
    while (!rv_a && n < 50) begin @(negedge clk); n++; end
    chk("stall_rsp_seen", {31'h0, rv_a}, 32'h1);
    hold_rd = rd_a; hold_err = err_a;
    chk("stall_rdata", hold_rd, erd);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, rv_a}, 32'h1);
      chk("stall_rdata_hold", rd_a, hold_rd);
      chk("stall_err_hold", {31'h0, err_a}, {31'h0, hold_err});
      chk("stall_req_ready", {31'h0, rdy_a}, 32'h0);
      chk("stall_busy", {31'h0, busy_a}, 32'h1);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("after_hs_req_ready", {31'h0, rdy_a}, 32'h1);
    chk("after_hs_valid", {31'h0, rv_a}, 32'h0);
    req_valid[0] = 1'b0;

    // Reset while a store is waiting: it must never land.
    do_op(0, 1, 0, 32'h20, 32'h11111111, "sw_20_init");
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_byte[0] = 1'b0;
    req_addr[0] = 32'h20; req_wdata[0] = 32'hAAAAAAAA; rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("drop_busy_before", {31'h0, busy_a}, 32'h1);
    rst = 1'b1;
    #1;
    chk("drop_rsp_valid", {31'h0, rv_a}, 32'h0);
    chk("drop_busy", {31'h0, busy_a}, 32'h0);
    chk("drop_req_ready", {31'h0, rdy_a}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 0, 0, 32'h20, 32'h0, "lw_20_after_drop");

    for (int i = 0; i < 16; i++) do_op(0, 1, 0, 32'(i * 4), $urandom, "fill_a");
    for (int i = 0; i < 30; i++)
      do_op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand_a");

    // Zero wait states: reset during EXEC also drops the store.
    do_op(1, 1, 0, 32'h20, 32'h11111111, "b_sw_20");
    do_op(1, 0, 0, 32'h20, 32'h0, "b_lw_20");
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_byte[1] = 1'b0;
    req_addr[1] = 32'h20; req_wdata[1] = 32'hAAAAAAAA; rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b1;
    #1 chk("b_drop_rsp_valid", {31'h0, rv_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 0, 0, 32'h20, 32'h0, "b_lw_20_after_drop");

    for (int i = 0; i < 16; i++) do_op(1, 1, 0, 32'(i * 4), $urandom, "fill_b");
    for (int i = 0; i < 20; i++)
      do_op(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand_b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
